fwrisc_uart_prog_loader: RTL and testbench

- Boot-time program loader inside the FPGA top.
- Deserialises UART bytes from the host link (8N1, LSB first), packs them little-endian into 32-bit words and writes them to instruction memory.
- Holds the core in reset until the full image is received.
- Flags progress, completion, overflow and framing errors to the host/bench.

---
 rtl/fwrisc_uart_prog_loader_if.sv | 12 +
 rtl/fwrisc_uart_prog_loader.sv | 182 ++++++++++++++++++
 tb/tb_fwrisc_uart_prog_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fwrisc_uart_prog_loader_if.sv
// Instruction-memory write bus driven by the UART program loader.
// The loader drives the bus through the master modport; the memory listens on the slave modport.
interface fwrisc_uart_prog_loader_if #(
   parameter int ADDR_W = 10
);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (output mem_we, output mem_addr, output mem_wdata);
   modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/fwrisc_uart_prog_loader.sv
// Boot-time loader: receives 8N1 UART bytes and packs them little-endian into 32-bit words.
// It writes each word to instruction memory and holds the CPU in reset until the full image has arrived.
module fwrisc_uart_prog_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PROG_BYTES   = 4096,
   parameter int ADDR_W       = 10
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               rx,
   fwrisc_uart_prog_loader_if.master          mem,
   output logic                               program_receiving,
   output logic                               program_done,
   output logic                               program_ov,
   output logic                               frame_err,
   output logic                               cpu_reset
);

   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int BCW_A  = $clog2(PROG_BYTES + 1);
   localparam int BCNT_W = (BCW_A > ADDR_W + 2) ? BCW_A : ADDR_W + 2;

   localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BCNT_W-1:0] BYTES_END = BCNT_W'(PROG_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } state_t;

   logic [1:0]        rx_sync_r;
   logic              rx_s;
   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [2:0]        bit_idx_r, bit_idx_s;
   logic [7:0]        shift_r, shift_s;
   logic              byte_ok_s;
   logic              stop_err_s;

   logic [BCNT_W-1:0] byte_cnt_r;
   logic [BCNT_W-1:0] byte_cnt_inc_s;
   logic [1:0]        lane_s;
   logic [31:0]       word_r, word_s;
   logic              last_byte_s;

   assign rx_s = rx_sync_r[1];

   // Two-flop synchroniser for the asynchronous serial line (idles high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_r <= 2'b11;
      end else begin
         rx_sync_r <= {rx_sync_r[0], rx};
      end
   end

   // Receiver state, bit-timing counter and data shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         bit_idx_r <= bit_idx_s;
         shift_r   <= shift_s;
      end
   end

   // Receiver next-state logic; byte_ok_s/stop_err_s mark the mid-stop-bit sample cycle.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      bit_idx_s  = bit_idx_r;
      shift_s    = shift_r;
      byte_ok_s  = 1'b0;
      stop_err_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cnt_s     = '0;
            bit_idx_s = 3'd0;
            if (!rx_s) state_s = ST_START;
            else       state_s = ST_IDLE;
         end
         ST_START: begin
            if (cnt_r == CNT_HALF) begin
               cnt_s = '0;
               if (!rx_s) state_s = ST_DATA;
               else       state_s = ST_IDLE;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (cnt_r == CNT_LAST) begin
               cnt_s     = '0;
               shift_s   = {rx_s, shift_r[7:1]};
               bit_idx_s = bit_idx_r + 3'd1;
               if (bit_idx_r == 3'd7) state_s = ST_STOP;
               else                   state_s = ST_DATA;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (cnt_r == CNT_LAST) begin
               cnt_s = '0;
               if (rx_s) begin
                  byte_ok_s = 1'b1;
                  state_s   = ST_IDLE;
               end else begin
                  stop_err_s = 1'b1;
                  state_s    = ST_WAIT_IDLE;
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_WAIT_IDLE: begin
            if (rx_s) state_s = ST_IDLE;
            else      state_s = ST_WAIT_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Word assembly: the received byte lands in the lane selected by the low byte-count bits.
   always_comb begin
      lane_s         = byte_cnt_r[1:0];
      byte_cnt_inc_s = byte_cnt_r + BCNT_W'(1);
      last_byte_s    = (byte_cnt_inc_s == BYTES_END);
      word_s         = word_r;
      word_s[{lane_s, 3'b000} +: 8] = shift_r;
   end

   // Loader outputs, all registered so every strobe appears one cycle after the stop-bit sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_r        <= '0;
         word_r            <= 32'h0000_0000;
         mem.mem_we        <= 1'b0;
         mem.mem_addr      <= '0;
         mem.mem_wdata     <= 32'h0000_0000;
         program_receiving <= 1'b0;
         program_done      <= 1'b0;
         program_ov        <= 1'b0;
         frame_err         <= 1'b0;
         cpu_reset         <= 1'b1;
      end else begin
         program_receiving <= 1'b0;
         mem.mem_we        <= 1'b0;
         frame_err         <= stop_err_s;
         if (byte_ok_s) begin
            if (program_done) begin
               program_ov <= 1'b1;
            end else begin
               program_receiving <= 1'b1;
               byte_cnt_r        <= byte_cnt_inc_s;
               word_r            <= word_s;
               if (lane_s == 2'd3) begin
                  mem.mem_we    <= 1'b1;
                  mem.mem_addr  <= byte_cnt_r[ADDR_W+1:2];
                  mem.mem_wdata <= word_s;
               end
               if (last_byte_s) begin
                  program_done <= 1'b1;
                  cpu_reset    <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fwrisc_uart_prog_loader.sv
// Scoreboard bench for fwrisc_uart_prog_loader: expected strobes are queued as bytes are sent.
// A monitor pops and compares an entry whenever the loader pulses a strobe.
module tb_fwrisc_uart_prog_loader;
   localparam int CPB    = 16;
   localparam int PBYTES = 32;
   localparam int AW     = 3;

   logic clk = 1'b0;
   logic rst_n, rx;
   logic program_receiving, program_done, program_ov, frame_err, cpu_reset;

   fwrisc_uart_prog_loader_if #(.ADDR_W(AW)) lif ();

   fwrisc_uart_prog_loader #(.CLKS_PER_BIT(CPB), .PROG_BYTES(PBYTES), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .mem(lif.master),
      .program_receiving(program_receiving), .program_done(program_done),
      .program_ov(program_ov), .frame_err(frame_err), .cpu_reset(cpu_reset));

   always #5 clk = ~clk;

   typedef struct packed {
      logic          recv;
      logic          we;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic          ferr;
      logic          done;
      logic          cpu_rst;
   } ev_t;

   ev_t sb_q[$];
   int  tests_run    = 0;
   int  tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic recv, input logic we, input logic [AW-1:0] addr,
                       input logic [31:0] wdata, input logic ferr, input logic done);
      ev_t e;
      e.recv = recv; e.we = we; e.addr = addr; e.wdata = wdata;
      e.ferr = ferr; e.done = done; e.cpu_rst = ~done;
      sb_q.push_back(e);
   endtask

   task automatic monitor();
      ev_t e;
      forever begin
         @(negedge clk);
         if (lif.mem_we || program_receiving || frame_err) begin
            if (sb_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL unexpected_event: recv=%b we=%b ferr=%b expected no event at %0t",
                        program_receiving, lif.mem_we, frame_err, $time);
            end else begin
               e = sb_q.pop_front();
               check("recv", {31'd0, program_receiving}, {31'd0, e.recv});
               check("mem_we", {31'd0, lif.mem_we}, {31'd0, e.we});
               check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
               check("program_done", {31'd0, program_done}, {31'd0, e.done});
               check("cpu_reset", {31'd0, cpu_reset}, {31'd0, e.cpu_rst});
               if (e.we) begin
                  check("mem_addr", {{(32-AW){1'b0}}, lif.mem_addr}, {{(32-AW){1'b0}}, e.addr});
                  check("mem_wdata", lif.mem_wdata, e.wdata);
               end
            end
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40 * CPB && sb_q.size() != 0; i++) @(posedge clk);
      check(name, sb_q.size(), 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      logic [31:0] wexp;
      rst_n = 1'b1;
      rx    = 1'b1;
      #3 rst_n = 1'b0;
      fork
         monitor();
      join_none

      // Reset state while rx toggles.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         rx = ~rx;
      end
      rx = 1'b1;
      @(negedge clk);
      check("rst_mem_we", {31'd0, lif.mem_we}, 32'd0);
      check("rst_mem_addr", {{(32-AW){1'b0}}, lif.mem_addr}, 32'd0);
      check("rst_mem_wdata", lif.mem_wdata, 32'd0);
      check("rst_recv", {31'd0, program_receiving}, 32'd0);
      check("rst_done", {31'd0, program_done}, 32'd0);
      check("rst_ov", {31'd0, program_ov}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // Single byte: one pulse, no write.
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      send_byte(8'hA5, 1'b1);
      wait_drain("drain_single");

      // Four bytes form one little-endian word at address 0.
      pulse_reset();
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      push(1'b1, 1'b1, 3'd0, 32'h4491_5467, 1'b0, 1'b0);
      send_byte(8'h67, 1'b1);
      send_byte(8'h54, 1'b1);
      send_byte(8'h91, 1'b1);
      send_byte(8'h44, 1'b1);
      wait_drain("drain_word0");
      check("hold_mem_addr", {{(32-AW){1'b0}}, lif.mem_addr}, 32'd0);
      check("hold_mem_wdata", lif.mem_wdata, 32'h4491_5467);

      // Framing error discards the byte; the retry lands in lane 0 of word 1.
      push(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      send_byte(8'h3C, 1'b0);
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      push(1'b1, 1'b1, 3'd1, 32'h0302_013C, 1'b0, 1'b0);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      wait_drain("drain_frame");

      // Short glitch: no activity expected.
      rx = 1'b0;
      repeat (CPB / 4) @(posedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      wait_drain("drain_glitch");

      // Break: exactly one framing error.
      push(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
      rx = 1'b0;
      repeat (14 * CPB) @(posedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      wait_drain("drain_break");

      // Two bytes stored, reset mid-DATA, then the next word must go to address 0.
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = i[0];
         repeat (CPB) @(posedge clk);
      end
      pulse_reset();
      rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      wait_drain("drain_prereset");
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      push(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      push(1'b1, 1'b1, 3'd0, 32'hEFBE_ADDE, 1'b0, 1'b0);
      send_byte(8'hDE, 1'b1);
      send_byte(8'hAD, 1'b1);
      send_byte(8'hBE, 1'b1);
      send_byte(8'hEF, 1'b1);
      wait_drain("drain_postreset");

      // Full image, byte i = i; done/cpu_reset change with the last byte.
      pulse_reset();
      wexp = 32'h0;
      for (int i = 0; i < PBYTES; i++) begin
         wexp[8 * (i % 4) +: 8] = 8'(i);
         push(1'b1, (i % 4) == 3, AW'(i / 4), wexp, 1'b0, i == PBYTES - 1);
         send_byte(8'(i), 1'b1);
      end
      wait_drain("drain_image");
      check("done_sticky", {31'd0, program_done}, 32'd1);
      check("cpu_released", {31'd0, cpu_reset}, 32'd0);
      check("ov_before", {31'd0, program_ov}, 32'd0);

      // Extra byte after completion: overflow only.
      send_byte(8'hFF, 1'b1);
      check("ov_after", {31'd0, program_ov}, 32'd1);
      check("done_after_ov", {31'd0, program_done}, 32'd1);
      wait_drain("drain_ov");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
